// File: rtl/data_pll_sequencer_pkg.sv
// Shared types and widths for the data-clock rPLL reprogramming sequencer.
package data_pll_seq_pkg;

  localparam int unsigned DIV_W   = 6;
  localparam int unsigned RETRY_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN,
    ST_FAIL
  } seq_state_e;

  typedef struct packed {
    logic [DIV_W-1:0] fbdsel;
    logic [DIV_W-1:0] idsel;
    logic [DIV_W-1:0] odsel;
  } div_cfg_t;

endpackage

// File: rtl/data_pll_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous rPLL lock into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/data_pll_sequencer.sv
// Sequences divider reprogramming, reset and lock qualification of the data-clock rPLL.
// Optional lock timeout / retry / FAIL path enabled by defining PLL_SEQ_LOCK_TIMEOUT_EN.
module data_pll_sequencer
  import data_pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = 27,
  parameter int unsigned SETTLE_CYCLES  = 2700,
  parameter int unsigned TIMEOUT_CYCLES = 270000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_fbdsel,
  input  logic [DIV_W-1:0]   cfg_idsel,
  input  logic [DIV_W-1:0]   cfg_odsel,
  output logic [DIV_W-1:0]   pll_fbdsel,
  output logic [DIV_W-1:0]   pll_idsel,
  output logic [DIV_W-1:0]   pll_odsel,
  output logic               pll_reset,
  input  logic               pll_lock,
  output logic               data_rst_n,
  output logic               locked,
  output logic               lol_sticky,
  output logic               error,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned MAX_RS    = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC   = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_CYC) + 1;
  localparam int unsigned RETRY_LIM = (MAX_RETRIES > 3) ? 3 : MAX_RETRIES;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  div_cfg_t           div_q, div_d;
  logic               pll_reset_q, pll_reset_d;
  logic               data_rst_n_q, data_rst_n_d;
  logic               locked_q, locked_d;
  logic               lol_q, lol_d;
  logic               error_q, error_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               lock_s;
  logic               xfer_c;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  assign xfer_c = cfg_valid && cfg_ready_q;

  // Next-state and next-output logic; an accepted transfer pre-empts every state action.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    pll_reset_d  = pll_reset_q;
    data_rst_n_d = data_rst_n_q;
    locked_d     = locked_q;
    lol_d        = lol_q;
    error_d      = error_q;
    retry_d      = retry_q;

    if (xfer_c) begin
      state_d      = ST_RESET;
      cnt_d        = '0;
      div_d        = div_cfg_t'{fbdsel: cfg_fbdsel, idsel: cfg_idsel, odsel: cfg_odsel};
      pll_reset_d  = 1'b1;
      data_rst_n_d = 1'b0;
      locked_d     = 1'b0;
      lol_d        = 1'b0;
      error_d      = 1'b0;
      retry_d      = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
            state_d     = ST_WAIT_LOCK;
            pll_reset_d = 1'b0;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else if (TIMEOUT_EN && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            cnt_d       = '0;
            pll_reset_d = 1'b1;
            if (retry_q < RETRY_W'(RETRY_LIM)) begin
              state_d = ST_RESET;
              retry_d = retry_q + RETRY_W'(1);
            end else begin
              state_d = ST_FAIL;
              error_d = 1'b1;
            end
          end else if (TIMEOUT_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d      = ST_RUN;
            data_rst_n_d = 1'b1;
            locked_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          // Lock loss keeps the dividers and PLL running; only the data path is held.
          if (!lock_s) begin
            state_d      = ST_WAIT_LOCK;
            cnt_d        = '0;
            data_rst_n_d = 1'b0;
            locked_d     = 1'b0;
            lol_d        = 1'b1;
          end
        end
        ST_IDLE, ST_FAIL: begin
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      pll_reset_q  <= 1'b1;
      data_rst_n_q <= 1'b0;
      locked_q     <= 1'b0;
      lol_q        <= 1'b0;
      error_q      <= 1'b0;
      retry_q      <= '0;
      cfg_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      pll_reset_q  <= pll_reset_d;
      data_rst_n_q <= data_rst_n_d;
      locked_q     <= locked_d;
      lol_q        <= lol_d;
      error_q      <= error_d;
      retry_q      <= retry_d;
      cfg_ready_q  <= cfg_ready_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign pll_fbdsel = div_q.fbdsel;
  assign pll_idsel  = div_q.idsel;
  assign pll_odsel  = div_q.odsel;
  assign pll_reset  = pll_reset_q;
  assign data_rst_n = data_rst_n_q;
  assign locked     = locked_q;
  assign lol_sticky = lol_q;
  assign error      = error_q;
  assign retry_cnt  = retry_q;

endmodule

// File: doc/data_pll_sequencer.md
# data_pll_sequencer

Sequences reprogramming of the dynamic-divider data-clock rPLL in the hsdaohSDR top level. It accepts a new divider triple (FBDSEL/IDSEL/ODSEL) over a valid/ready handshake and holds the PLL in reset while the dividers change. It then waits for a stable lock before releasing the ADC-to-FIFO write path, and reports lock, loss-of-lock and failure status back to the UART/I2C settings bridge. It replaces direct register-bit drive of the PLL reset and divider pins.

## Interface
- RESET_CYCLES, 27: cycles pll_reset is held high per attempt (1 µs at 27 MHz).
- SETTLE_CYCLES, 2700: consecutive synchronized-lock cycles required before RUN.
- TIMEOUT_CYCLES, 270000: WAIT_LOCK cycles before an attempt fails (timeout build only).
- MAX_RETRIES, 3: extra attempts after the first timeout before FAIL (timeout build only).
- clk  in  1  sys_clk domain; one clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  new divider triple offered.
- cfg_ready  out  1  high in IDLE, RUN, FAIL.
- cfg_fbdsel / cfg_idsel / cfg_odsel  in  6 each  requested divider codes.
- pll_fbdsel / pll_idsel / pll_odsel  out  6 each  to rPLL FBDSEL/IDSEL/ODSEL.
- pll_reset  out  1  to rPLL RESET.
- pll_lock  in  1  rPLL LOCK, asynchronous to clk.
- data_rst_n  out  1  active-low hold for the data-domain FIFO write side.
- locked  out  1  high only in RUN.
- lol_sticky  out  1  set on lock loss in RUN; cleared on cfg accept.
- error  out  1  high in FAIL.
- retry_cnt  out  2  attempts consumed in the current sequence.

## Operation
- Handshake: a transfer occurs on a rising edge with cfg_valid && cfg_ready. cfg_valid is ignored while cfg_ready is low; requests are not queued.
- States: IDLE, RESET, WAIT_LOCK, SETTLE, RUN, FAIL.
- Reset (rst_n low at an edge) moves to IDLE with these register values:
  - pll_reset=1, pll_*sel=0, data_rst_n=0.
  - locked=0, lol_sticky=0, error=0, retry_cnt=0, cfg_ready=1.
  - The PLL stays in reset until the first configuration is accepted.
- IDLE/RUN/FAIL + transfer -> RESET:
  - pll_*sel load the cfg values; pll_reset=1, data_rst_n=0, locked=0.
  - lol_sticky=0, error=0, retry_cnt=0, cycle counter cleared.
- RESET: count RESET_CYCLES, then go to WAIT_LOCK with pll_reset=0 and the counter cleared.
- WAIT_LOCK:
  - lock_s (2-flop synchronized pll_lock) high -> SETTLE, counter cleared.
  - Timeout build, counter == TIMEOUT_CYCLES-1:
    - retry_cnt < MAX_RETRIES: retry_cnt+1, go to RESET.
    - otherwise: go to FAIL.
- SETTLE:
  - lock_s low -> WAIT_LOCK; the timeout counter restarts.
  - SETTLE_CYCLES consecutive high cycles -> RUN with data_rst_n=1, locked=1.
- RUN: lock_s low -> WAIT_LOCK with data_rst_n=0, locked=0, lol_sticky=1. Dividers are unchanged and there is no PLL reset.
- FAIL: pll_reset=1, error=1, data_rst_n=0. The block stays here until a new transfer or rst_n.
- Simultaneous events:
  - Transfer in the same cycle as a lock drop in RUN: the transfer wins and the next state is RESET.
  - rst_n low overrides everything.
- Counters are $clog2(max param)+1 bits wide. retry_cnt saturates at 3.

## Timing
- All outputs are registered. Transfer at edge N: pll_reset=1, new pll_*sel and data_rst_n=0 are visible after edge N.
- pll_reset is high for exactly RESET_CYCLES cycles per attempt.
- Lock-to-release latency:
  - 2 synchronizer cycles, plus 1 cycle to enter SETTLE, plus SETTLE_CYCLES.
  - data_rst_n rises SETTLE_CYCLES+3 cycles after the first lock-high edge, if lock stays high.
- Lock loss in RUN: data_rst_n falls 3 cycles after pll_lock falls (2 synchronizer + 1 register).
- Dividers never change while pll_reset is low.

## Configuration
- PLL_SEQ_LOCK_TIMEOUT_EN defined: the WAIT_LOCK timeout, the retry path and the FAIL state are present.
- PLL_SEQ_LOCK_TIMEOUT_EN undefined:
  - WAIT_LOCK waits indefinitely; FAIL is unreachable.
  - error and retry_cnt are tied to 0; TIMEOUT_CYCLES and MAX_RETRIES are unused.

## Structure
- Package data_pll_seq_pkg holds:
  - the state enum;
  - the divider width constant (6);
  - the retry_cnt width constant (2).
- Sub-module sync_2ff synchronizes pll_lock into clk. Its reset value is 0.

## Test plan
Bench parameters: RESET_CYCLES=4, SETTLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Reset then idle -> pll_reset=1, pll_*sel=0, data_rst_n=0, cfg_ready=1, locked=0.
- Send fbd=18, id=6, od=16; assert lock 10 cycles after pll_reset falls:
  - pll_reset is high for exactly 4 cycles;
  - sel outputs = 18/6/16;
  - data_rst_n rises 11 cycles after lock.
- In RUN, drop lock for 5 cycles, then restore:
  - data_rst_n falls 3 cycles after the drop; lol_sticky=1;
  - RUN is re-entered 11 cycles after restore, with no pll_reset pulse.
- Glitch lock high for 3 cycles during SETTLE -> returns to WAIT_LOCK; data_rst_n stays 0.
- Timeout build, lock never asserts:
  - 3 pll_reset pulses, 32 WAIT_LOCK cycles apart;
  - retry_cnt steps 0,1,2, then error=1 and cfg_ready=1.
  - A new transfer then clears error.
- Transfer in the same cycle as a lock drop in RUN -> RESET entered, with new dividers the next cycle. rst_n low mid-SETTLE -> IDLE reset values the next cycle.
